seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_addsub.sv | 16 +
 rtl/seq_divider.sv | 148 ++++++++++++++
 tb/tb_seq_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential non-restoring divider.
package div_pkg;

   localparam int DEF_WIDTH = 32;

   // Counter must hold 0..WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } state_t;

endpackage

// File: rtl/div_addsub.sv
// One (WIDTH+1)-bit add/subtract step of the non-restoring divider; the
// divisor is zero-extended because it is always a magnitude here.
module div_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] d,
   input  logic             sub,
   output logic [WIDTH:0]   r_next,
   output logic             sign
);

   assign r_next = sub ? (r - {1'b0, d}) : (r + {1'b0, d});
   assign sign   = r_next[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Radix-2 non-restoring divider behind a start/done handshake.
// Define DIV_SIGNED_EN to honour signed_op; otherwise every divide is unsigned.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output state_t           dbg_state
);

   // Handshake: start is taken only in IDLE; busy covers the cycles after
   // acceptance up to (not including) the single-cycle done pulse.
   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH:0]   r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   as_a;
   logic [WIDTH:0]   as_y;
   logic             as_sub;
   logic             as_sign;
   logic [WIDTH:0]   r_fix;
   logic [WIDTH-1:0] abs_q;
   logic [WIDTH-1:0] abs_d;
   logic [WIDTH-1:0] q_out;
   logic [WIDTH-1:0] r_out;

`ifdef DIV_SIGNED_EN
   logic sop;
   logic neg_q;
   logic neg_r;
`else
   logic unused_signed_op;
   assign unused_signed_op = signed_op;
`endif

   assign dbg_state = state;

   // The step unit shifts {R,Q} in ITER and performs the final restore in FIX.
   always_comb begin
      as_a   = (state == ITER) ? {r_reg[WIDTH-1:0], q_reg[WIDTH-1]} : r_reg;
      as_sub = (state == ITER) ? ~r_reg[WIDTH] : 1'b0;
      r_fix  = r_reg[WIDTH] ? as_y : r_reg;
`ifdef DIV_SIGNED_EN
      abs_q = (sop && q_reg[WIDTH-1]) ? -q_reg : q_reg;
      abs_d = (sop && d_reg[WIDTH-1]) ? -d_reg : d_reg;
      q_out = neg_q ? -q_reg : q_reg;
      r_out = neg_r ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
`else
      abs_q = q_reg;
      abs_d = d_reg;
      q_out = q_reg;
      r_out = r_fix[WIDTH-1:0];
`endif
   end

   div_addsub #(.WIDTH(WIDTH)) u_addsub (
      .r      (as_a),
      .d      (d_reg),
      .sub    (as_sub),
      .r_next (as_y),
      .sign   (as_sign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         r_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         count       <= '0;
`ifdef DIV_SIGNED_EN
         sop         <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  q_reg <= dividend;
                  d_reg <= divisor;
                  busy  <= 1'b1;
                  state <= PREP;
`ifdef DIV_SIGNED_EN
                  sop   <= signed_op;
                  neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_r <= signed_op & dividend[WIDTH-1];
`endif
               end
            end
            PREP: begin
               if (d_reg == '0) begin
                  quotient    <= '1;
                  remainder   <= q_reg;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  q_reg <= abs_q;
                  d_reg <= abs_d;
                  r_reg <= '0;
                  count <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               r_reg <= as_y;
               q_reg <= {q_reg[WIDTH-2:0], ~as_sign};
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               quotient    <= q_out;
               remainder   <= r_out;
               div_by_zero <= 1'b0;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider (WIDTH=32); expectations follow
// whether DIV_SIGNED_EN is defined for the build.
module tb_seq_divider;
   import div_pkg::*;

   localparam int W   = 32;
   localparam int LAT = W + 2;

`ifdef DIV_SIGNED_EN
   localparam logic [W-1:0] M7D2_Q  = 32'hFFFF_FFFD;
   localparam logic [W-1:0] M7D2_R  = 32'hFFFF_FFFF;
   localparam logic [W-1:0] P7DM2_Q = 32'hFFFF_FFFD;
   localparam logic [W-1:0] P7DM2_R = 32'h0000_0001;
   localparam logic [W-1:0] OVF_Q   = 32'h8000_0000;
   localparam logic [W-1:0] OVF_R   = 32'h0000_0000;
`else
   localparam logic [W-1:0] M7D2_Q  = 32'h7FFF_FFFC;
   localparam logic [W-1:0] M7D2_R  = 32'h0000_0001;
   localparam logic [W-1:0] P7DM2_Q = 32'h0000_0000;
   localparam logic [W-1:0] P7DM2_R = 32'h0000_0007;
   localparam logic [W-1:0] OVF_Q   = 32'h0000_0000;
   localparam logic [W-1:0] OVF_R   = 32'h8000_0000;
`endif

   logic         clk;
   logic         rst;
   logic         start;
   logic         signed_op;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   state_t       dbg_state;

   logic [2*W:0] exp_q[$];
   int           exp_cyc_q[$];
   int           cyc;
   int           n_checks;
   int           n_pass;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // driver: call while the DUT is idle (or in its done cycle), away from posedge
   task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] qe, input logic [W-1:0] re, input logic dze,
                        input bit push);
      signed_op = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         exp_q.push_back({qe, re, dze});
         exp_cyc_q.push_back(cyc + ((b == '0) ? 1 : LAT));
      end
   endtask

   task automatic wait_done(input string tag);
      int i;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) break;
      end
      n_checks++;
      if (i < 100) n_pass++;
      else $display("FAIL timeout_%s: no done within 100 cycles, expected one", tag);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
         end else begin
            logic [2*W:0] e;
            int           ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("quotient", 64'(quotient), 64'(e[2*W:W+1]));
            chk("remainder", 64'(remainder), 64'(e[W:1]));
            chk("div_by_zero", 64'(div_by_zero), 64'(e[0]));
            chk("done_cycle", 64'(cyc), 64'(ec));
            chk("busy_at_done", 64'(busy), 64'(0));
         end
      end
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      n_checks  = 0;
      n_pass    = 0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_quotient", 64'(quotient), 64'(0));
      chk("rst_remainder", 64'(remainder), 64'(0));
      chk("rst_dbz", 64'(div_by_zero), 64'(0));
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      rst = 1'b0;
      @(negedge clk);

      issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      @(negedge clk);
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("no_early_done", 64'(done), 64'(0));
      wait_done("u100_7");
      repeat (2) @(negedge clk);

      issue(1'b1, 32'hFFFF_FFF9, 32'd2, M7D2_Q, M7D2_R, 1'b0, 1'b1);
      wait_done("m7_2");
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, P7DM2_Q, P7DM2_R, 1'b0, 1'b1);
      wait_done("p7_m2");
      issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
      wait_done("dbz_u");
      issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
      wait_done("dbz_s");
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, OVF_Q, OVF_R, 1'b0, 1'b1);
      wait_done("ovf_s");
      issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1);
      wait_done("ovf_u");
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
      wait_done("max_1");
      issue(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1);
      wait_done("small");
      repeat (3) @(negedge clk);

      // start pulsed mid-operation must be ignored
      issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      dividend = 32'd9;
      divisor  = 32'd9;
      start    = 1'b1;
      chk("busy_mid_op", 64'(busy), 64'(1));
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignored_start");

      // start in the done cycle is accepted
      issue(1'b0, 32'd12345, 32'd12345, 32'd1, 32'd0, 1'b0, 1'b1);
      wait_done("b2b_first");
      issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      wait_done("b2b_second");
      repeat (2) @(negedge clk);

      // reset at cycle 10 of an operation
      issue(1'b0, 32'd77, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_quotient", 64'(quotient), 64'(0));
      chk("midrst_remainder", 64'(remainder), 64'(0));
      chk("midrst_state", 64'(dbg_state), 64'(IDLE));
      repeat (40) @(negedge clk);

      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
